// File: rtl/serial_alu_ctrl_pkg.sv
// serial_alu_ctrl_pkg: op encodings, FSM state type and default width shared by serial_alu_ctrl (flags via SERIAL_ALU_FLAGS_EN)
package serial_alu_ctrl_pkg;
    localparam int DEFAULT_WIDTH = 16;
    localparam logic [1:0] OP_OR  = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_SLT = 2'd3;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/serial_alu_ctrl_bit_slice.sv
// alu_bit_slice: combinational 1-bit OR/ADD/SUB slice; SUB and SLT invert b and rely on carry-in for the +1
module alu_bit_slice
    import serial_alu_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       ci,
    input  logic [1:0] op,
    output logic       r,
    output logic       co
);
    logic w_or;
    logic w_bx;
    assign w_or = (op == OP_OR);
    assign w_bx = (op == OP_SUB || op == OP_SLT) ? ~b : b;
    assign r    = w_or ? (a | b) : (a ^ w_bx ^ ci);
    assign co   = w_or ? 1'b0 : ((a & w_bx) | (ci & (a ^ w_bx)));
endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU controller, LSB first through one reused slice; SERIAL_ALU_FLAGS_EN adds zero/ovf outputs
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_sum;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             w_r;
    logic             w_co;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

    alu_bit_slice u_slice (
        .a  (r_a[r_cnt]),
        .b  (r_b[r_cnt]),
        .ci (r_carry),
        .op (r_op),
        .r  (w_r),
        .co (w_co)
    );

    assign ready      = (r_state == S_IDLE) || (r_state == S_DONE);
    assign done       = (r_state == S_DONE);
    assign result     = r_result;
    assign cout       = r_cout;
    assign w_accept   = ready && start;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    // r_sum holds bits 0..WIDTH-2 by the final RUN cycle; the slice supplies the MSB live
    assign w_res_next = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_r} : {w_r, r_sum};

`ifdef SERIAL_ALU_FLAGS_EN
    logic r_zero;
    logic r_ovf;
    assign zero = r_zero;
    assign ovf  = r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_op     <= OP_OR;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_carry <= (op == OP_SUB) || (op == OP_SLT);
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
        end else if (r_state == S_RUN) begin
            r_cnt   <= r_cnt + 1'b1;
            r_carry <= w_co;
            r_sum   <= (r_sum >> 1) | ((WIDTH-1)'(w_r) << (WIDTH - 2));
            if (w_last) begin
                r_state  <= S_DONE;
                r_result <= w_res_next;
                r_cout   <= w_co;
`ifdef SERIAL_ALU_FLAGS_EN
                r_zero   <= (w_res_next == '0);
                // carry into MSB is r_carry, carry out is w_co
                r_ovf    <= ((r_op == OP_ADD) || (r_op == OP_SUB)) && (r_carry ^ w_co);
`endif
            end
        end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; legal values 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled only while ready=1.
REQ-005 Port: op  input  2  operation: 0=OR, 1=ADD, 2=SUB, 3=SLT; sampled with start.
REQ-006 Port: a  input  WIDTH  first operand; sampled with start.
REQ-007 Port: b  input  WIDTH  second operand; sampled with start.
REQ-008 Port: ready  output  1  high in IDLE and DONE; controller can accept start.
REQ-009 Port: done  output  1  one-cycle pulse; result and cout are valid from this cycle.
REQ-010 Port: result  output  WIDTH  operation result; held until the next accepted start.
REQ-011 Port: cout  output  1  carry out of bit WIDTH-1 (ADD/SUB/SLT); 0 for OR.

Function
REQ-012 Datapath: a single 1-bit slice is reused, one bit per cycle, LSB first; no WIDTH-bit adder is instantiated.
REQ-013 The FSM has states IDLE, RUN, DONE. Reset enters IDLE.
REQ-014 IDLE/DONE with start=1: latch a, b and op; load bit counter=0; load carry=1 for SUB/SLT, 0 for OR/ADD; go to RUN.
REQ-015 RUN: each cycle, process bit[counter]; store sum/OR bit; carry register <= slice carry-out; counter++.
REQ-016 Slice function: OR -> a|b; ADD -> a+b+c; SUB/SLT -> a+~b+c.
REQ-017 RUN lasts exactly WIDTH cycles; when counter=WIDTH-1, go to DONE and write result/cout.
REQ-018 Latency: start accepted at edge t -> done=1 in the cycle after edge t+WIDTH (WIDTH+1 cycles from start to done).
REQ-019 SLT: result = {(WIDTH-1) zeros, sum bit WIDTH-1 of a-b}; no overflow correction (signed-sum MSB rule).
REQ-020 Arithmetic wraps modulo 2^WIDTH; the carry out of the MSB appears only on cout.
REQ-021 DONE lasts one cycle; with start=0 go to IDLE; with start=1 a new operation is accepted (back-to-back, no bubble).
REQ-022 start while in RUN is ignored; the operands latched earlier stay unchanged.
REQ-023 result and cout change only on the DONE-entry edge; they are stable in all other cycles.

Reset
REQ-024 rst asserted at any time, including mid-RUN, forces IDLE within the same cycle, asynchronously.
REQ-025 Reset values: ready=1, done=0, result=0, cout=0, counter=0, carry=0, latched operands=0.
REQ-026 An operation interrupted by reset produces no done and leaves result=0.

Configuration
REQ-027 Macro SERIAL_ALU_FLAGS_EN defined: adds outputs zero (result==0) and ovf (signed overflow for ADD/SUB, 0 for OR/SLT).
REQ-028 Both flags use the same timing as result and reset to 0.
REQ-029 ovf is computed as the carry into the MSB XOR the carry out of the MSB.
REQ-030 Macro undefined: the zero and ovf ports and their logic are absent; all other behaviour is identical.

Structure
REQ-031 Shared package contains: op encodings (OP_OR, OP_ADD, OP_SUB, OP_SLT), the FSM state typedef, and the default WIDTH constant.
REQ-032 One sub-module, alu_bit_slice, contains the combinational 1-bit OR/ADD/SUB datapath (inputs a, b, ci, op; outputs r, co); the controller instantiates it once.

Verification
REQ-033 ADD 0x1234+0x0F0F, WIDTH=16 -> done 17 cycles after start; result=0x2143, cout=0.
REQ-034 SUB 0x0003-0x0005 -> result=0xFFFE, cout=0; SLT 3,5 -> result=0x0001; SLT 5,3 -> result=0x0000.
REQ-035 ADD 0xFFFF+0x0001 -> result=0x0000, cout=1; with SERIAL_ALU_FLAGS_EN, zero=1 and ovf=0; ADD 0x7FFF+1 -> ovf=1.
REQ-036 OR 0xA0A0|0x0505 -> result=0xA5A5, cout=0; start pulsed mid-RUN -> ignored, and this result is unchanged.
REQ-037 Assert rst at RUN cycle 8 -> next cycle ready=1, result=0, no done pulse; a new ADD 1+1 then gives result=0x0002.
REQ-038 Back-to-back run: start held high through DONE -> second op accepted at DONE, and its done pulse arrives 17 cycles later.
